// File: rtl/hash_cmd_arbiter_pkg.sv
// Channel interface types shared by the hash command arbiter, its tag FIFO and the clients.
// Also holds the round-robin index helper used by the arbiter.
package CHANNELS_P;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] data;
  } ch_hash_cmd_intf_struct;

  typedef struct packed {
    logic        valid;
    logic [31:0] hash;
  } ch_hash_ret_intf_struct;

  function automatic int rr_index(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/hash_tag_fifo.sv
// In-order tag FIFO: remembers which client issued each outstanding hash command.
// Pointers wrap naturally because DEPTH is a power of two.
module hash_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/hash_cmd_arbiter.sv
// Round-robin arbiter funnelling client hash commands into one engine and routing
// the in-order returns back to the issuing client through a tag FIFO.
module hash_cmd_arbiter
  import CHANNELS_P::*;
#(
  parameter int NUM_CH          = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  ch_hash_cmd_intf_struct               ch_hash_cmd_intf_in [NUM_CH],
  output logic [NUM_CH-1:0]                    ch_hash_cmd_intf_in_ready,
  output ch_hash_cmd_intf_struct               ch_hash_cmd_intf_out,
  input  logic                                 ch_hash_cmd_intf_out_ready,
  input  ch_hash_ret_intf_struct               ch_hash_ret_intf_in,
  output logic                                 ch_hash_ret_intf_in_ready,
  output ch_hash_ret_intf_struct               ch_hash_ret_intf_out [NUM_CH],
  input  logic [NUM_CH-1:0]                    ch_hash_ret_intf_out_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_spurious_ret
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CH_W-1:0]        last_grant;
  logic [CH_W-1:0]        grant_idx;
  logic                   grant_found;
  logic                   grant;
  logic                   out_free;
  ch_hash_cmd_intf_struct cmd_sel;
  ch_hash_cmd_intf_struct cmd_p1;

  logic [CH_W-1:0]        head_tag;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [CNT_W-1:0]       fifo_count;
  logic                   head_ready;
  logic                   ret_pop;

  // Stage p0: round-robin search starting just after the previous winner.
  always_comb begin
    int cand;
    cand        = 0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = rr_index(int'(last_grant), k, NUM_CH);
      if (!grant_found && ch_hash_cmd_intf_in[cand].valid) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
  end

  // A return popping this cycle does not free a slot until the count updates.
  assign out_free = !cmd_p1.valid || ch_hash_cmd_intf_out_ready;
  assign grant    = grant_found && out_free && !fifo_full && !reset;
  assign cmd_sel  = ch_hash_cmd_intf_in[grant_idx];

  always_comb begin
    ch_hash_cmd_intf_in_ready = '0;
    if (grant) ch_hash_cmd_intf_in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (grant) begin
      last_grant <= grant_idx;
    end
  end

  // Stage p1: engine-facing command register; only its valid bit is reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      cmd_p1 <= cmd_sel;
    end else if (ch_hash_cmd_intf_out_ready) begin
      cmd_p1.valid <= 1'b0;
    end
    if (reset) cmd_p1.valid <= 1'b0;
  end

  assign ch_hash_cmd_intf_out = cmd_p1;

  hash_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (grant_idx),
    .pop       (ret_pop),
    .head      (head_tag),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign outstanding = fifo_count;

  // Return path is combinational: the head tag steers the engine return straight through.
  always_comb begin
    head_ready = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ch_hash_ret_intf_out[ch] = '0;
      if (!fifo_empty && head_tag == CH_W'(ch)) begin
        ch_hash_ret_intf_out[ch] = ch_hash_ret_intf_in;
        head_ready               = ch_hash_ret_intf_out_ready[ch];
      end
    end
  end

  assign ch_hash_ret_intf_in_ready = !fifo_empty && head_ready && !reset;
  assign ret_pop = ch_hash_ret_intf_in.valid && ch_hash_ret_intf_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_spurious_ret <= 1'b0;
    end else if (ch_hash_ret_intf_in.valid && fifo_empty) begin
      err_spurious_ret <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hash_cmd_arbiter.sv
// Bench for hash_cmd_arbiter: vector table, directed corner sequences, then random traffic
// checked every cycle against a queue-based reference model.
module tb_hash_cmd_arbiter;
  import CHANNELS_P::*;

  localparam int NUM_CH = 4;
  localparam int MAXO   = 8;

  logic clk = 1'b0;
  logic reset;
  ch_hash_cmd_intf_struct cmd_in [NUM_CH];
  logic [NUM_CH-1:0]      cmd_in_ready;
  ch_hash_cmd_intf_struct cmd_out;
  logic                   cmd_out_ready;
  ch_hash_ret_intf_struct ret_in;
  logic                   ret_in_ready;
  ch_hash_ret_intf_struct ret_out [NUM_CH];
  logic [NUM_CH-1:0]      ret_out_ready;
  logic [3:0]             outstanding;
  logic                   err;

  always #5 clk = ~clk;

  hash_cmd_arbiter #(.NUM_CH(NUM_CH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .ch_hash_cmd_intf_in        (cmd_in),
    .ch_hash_cmd_intf_in_ready  (cmd_in_ready),
    .ch_hash_cmd_intf_out       (cmd_out),
    .ch_hash_cmd_intf_out_ready (cmd_out_ready),
    .ch_hash_ret_intf_in        (ret_in),
    .ch_hash_ret_intf_in_ready  (ret_in_ready),
    .ch_hash_ret_intf_out       (ret_out),
    .ch_hash_ret_intf_out_ready (ret_out_ready),
    .outstanding                (outstanding),
    .err_spurious_ret           (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: arbitration pointer, queue of issued channel ids, output slot, sticky error.
  int m_last = NUM_CH - 1;
  int m_q[$];
  bit m_vld = 1'b0;
  ch_hash_cmd_intf_struct m_cmd;
  bit m_err = 1'b0;
  int p_gidx;
  bit p_grant = 1'b0;
  bit p_rready = 1'b0;

  typedef struct {
    bit       rst;
    bit [3:0] vmask;
    bit       ordy;
    bit       rvld;
    bit [3:0] rrdy;
    bit [3:0] e_cr;
    bit       e_rr;
    int       e_out;
    bit       e_ovld;
    bit       e_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit [3:0] vm, input bit ordy, input bit rvld,
                       input bit [3:0] rrdy);
    reset = rst;
    for (int i = 0; i < NUM_CH; i++) begin
      cmd_in[i].valid = vm[i];
      cmd_in[i].op    = 4'($urandom);
      cmd_in[i].data  = $urandom;
    end
    cmd_out_ready = ordy;
    ret_in.valid  = rvld;
    ret_in.hash   = $urandom;
    ret_out_ready = rrdy;
  endtask

  task automatic eval();
    bit [3:0] exp_cr;
    bit       expv;
    #3;
    p_gidx = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_last + k) % NUM_CH;
      if (p_gidx < 0 && cmd_in[c].valid) p_gidx = c;
    end
    p_grant = !reset && (p_gidx >= 0) && (!m_vld || cmd_out_ready) && (m_q.size() < MAXO);
    exp_cr  = p_grant ? (4'b0001 << p_gidx) : 4'b0000;
    chk("cmd_in_ready", cmd_in_ready, exp_cr);
    chk("cmd_out_valid", cmd_out.valid, m_vld);
    if (m_vld) chk("cmd_out_payload", {cmd_out.op, cmd_out.data}, {m_cmd.op, m_cmd.data});
    chk("outstanding", outstanding, m_q.size());
    chk("err_spurious_ret", err, m_err);
    p_rready = !reset && (m_q.size() > 0) && ret_out_ready[m_q[0]];
    chk("ret_in_ready", ret_in_ready, p_rready);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      expv = (m_q.size() > 0) && (m_q[0] == ch) && ret_in.valid;
      chk($sformatf("ret_out_valid[%0d]", ch), ret_out[ch].valid, expv);
      if (expv) chk($sformatf("ret_out_hash[%0d]", ch), ret_out[ch].hash, ret_in.hash);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_last = NUM_CH - 1;
      m_q.delete();
      m_vld = 1'b0;
      m_err = 1'b0;
    end else begin
      if (ret_in.valid && m_q.size() == 0) m_err = 1'b1;
      if (ret_in.valid && p_rready) void'(m_q.pop_front());
      if (p_grant) begin
        m_q.push_back(p_gidx);
        m_last = p_gidx;
        m_vld  = 1'b1;
        m_cmd  = cmd_in[p_gidx];
      end else if (cmd_out_ready) begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cycle(input bit rst, input bit [3:0] vm, input bit ordy, input bit rvld,
                       input bit [3:0] rrdy);
    drive(rst, vm, ordy, rvld, rrdy);
    eval();
    tick();
  endtask

  initial begin
    int grants;
    // rst vmask ordy rvld rrdy | cready rready outstanding out_valid err
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'hF, 4'h2, 1'b1, 1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'hF, 4'h4, 1'b1, 1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'hB, 4'h8, 1'b0, 1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'h5, 1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'h4, 1'b1, 1'b0, 4'hF, 4'h4, 1'b1, 1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b1, 2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b1, 1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 4'h0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 0, 1'b0, 1'b0};

    drive(1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].vmask, tbl[i].ordy, tbl[i].rvld, tbl[i].rrdy);
      eval();
      chk($sformatf("tbl%0d cready", i), cmd_in_ready, tbl[i].e_cr);
      chk($sformatf("tbl%0d rready", i), ret_in_ready, tbl[i].e_rr);
      chk($sformatf("tbl%0d outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("tbl%0d out_valid", i), cmd_out.valid, tbl[i].e_ovld);
      chk($sformatf("tbl%0d err", i), err, tbl[i].e_err);
      tick();
    end

    // Streaming: one grant per cycle in rotation, each return back to its issuer.
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 4'hF);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'hF, 1'b1, (i > 0), 4'hF);
      eval();
      chk("stream cready", cmd_in_ready, 4'b0001 << (i % 4));
      if (i > 0) begin
        chk("stream ret_valid", ret_out[(i - 1) % 4].valid, 1'b1);
        chk("stream outstanding", outstanding, 1);
      end
      tick();
    end

    // Fill the tag FIFO, then one return must not unblock a grant in the same cycle.
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 4'h0);
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'hF, 1'b1, 1'b0, 4'h0);
      eval();
      if (cmd_in_ready != 0) grants++;
      tick();
    end
    chk("full grant count", grants, 8);
    chk("full outstanding", outstanding, 8);
    drive(1'b0, 4'hF, 1'b1, 1'b1, 4'hF);
    eval();
    chk("full pop rready", ret_in_ready, 1'b1);
    chk("full pop same-cycle cready", cmd_in_ready, 4'h0);
    tick();
    drive(1'b0, 4'hF, 1'b1, 1'b0, 4'hF);
    eval();
    chk("resume outstanding", outstanding, 7);
    chk("resume cready", cmd_in_ready, 4'h1);
    tick();
    chk("refill outstanding", outstanding, 8);

    // Head tag 2 blocked by its client.
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 4'hF);
    cycle(1'b0, 4'h4, 1'b1, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b1, 4'hB);
      eval();
      chk("blocked rready", ret_in_ready, 1'b0);
      chk("blocked head valid", ret_out[2].valid, 1'b1);
      chk("blocked others valid", {ret_out[0].valid, ret_out[1].valid, ret_out[3].valid}, 3'b000);
      tick();
    end
    drive(1'b0, 4'h0, 1'b1, 1'b1, 4'hF);
    eval();
    chk("unblocked rready", ret_in_ready, 1'b1);
    tick();
    chk("unblocked outstanding", outstanding, 0);

    // Spurious return is sticky until reset.
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 4'hF);
    drive(1'b0, 4'h0, 1'b1, 1'b1, 4'hF);
    eval();
    chk("spurious rready", ret_in_ready, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0, 4'hF);
      eval();
      chk("spurious sticky", err, 1'b1);
      tick();
    end
    cycle(1'b1, 4'h0, 1'b1, 1'b0, 4'hF);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 4'hF);
    eval();
    chk("spurious cleared", err, 1'b0);
    tick();

    // Reset with five commands in flight discards their tags.
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'hF, 1'b1, 1'b0, 4'h0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
    eval();
    chk("midreset before", outstanding, 5);
    tick();
    drive(1'b1, 4'hF, 1'b1, 1'b0, 4'hF);
    eval();
    chk("midreset cready during reset", cmd_in_ready, 4'h0);
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b1, 4'hF);
    eval();
    chk("midreset outstanding", outstanding, 0);
    chk("midreset out_valid", cmd_out.valid, 1'b0);
    chk("midreset stale return rready", ret_in_ready, 1'b0);
    tick();
    drive(1'b0, 4'hF, 1'b1, 1'b0, 4'hF);
    eval();
    chk("midreset stale return err", err, 1'b1);
    chk("midreset first grant", cmd_in_ready, 4'h1);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] rr;
      for (int b = 0; b < 4; b++) rr[b] = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
